pueo_uram_readout_ctrl: RTL and testbench
=========================================

Name: pueo_uram_readout_ctrl

Overview:
- Consumer/requester side of the per-channel URAM sample buffer readout, in the memclk (500 MHz) domain.
- On a trigger, computes the pretrigger-adjusted base address and issues one read request to the buffer.
- Absorbs the RDLEN 72-bit words (6 x 12-bit samples each) into a local FIFO, giving the buffer the early-warning ready it requires.
- Re-emits the words as a true AXI4-Stream with tlast.

Parameters:
- ADDRLEN, 14, URAM buffer address width (buffer depth 2^ADDRLEN words).
- ADDRBITS, 16, request-channel data width; base address zero-extended to this.
- RDLEN, 1024, words returned per request.
- PRETRIG, 256, words subtracted from trigger address; must be < 2^ADDRLEN.
- FIFO_DEPTH, 16, local FIFO depth in words; power of 2, >= 2*MARGIN.
- MARGIN, 4, free-slot notice the buffer needs before it stops writing.

Ports:
- memclk, in, 1, single clock for the whole block.
- memclk_rstn_i, in, 1, asynchronous active-low reset.
- trig_i, in, 1, single-cycle trigger pulse.
- trig_addr_i, in, ADDRLEN, buffer write address captured with trig_i.
- busy_o, in/out: out, 1, high in any state other than IDLE.
- m_req_tdata, out, ADDRBITS, base read address to buffer.
- m_req_tvalid, out, 1, request valid.
- m_req_tready, in, 1, buffer accepts request.
- s_dat_tdata, in, 72, readout word from buffer.
- s_dat_tvalid, in, 1, readout word valid.
- s_dat_tready, out, 1, early-warning ready: FIFO free slots > MARGIN.
- m_axis_tdata, out, 72, output word.
- m_axis_tvalid, out, 1, output valid.
- m_axis_tready, in, 1, downstream ready.
- m_axis_tlast, out, 1, high on word RDLEN-1 of the event.
- overflow_o, out, 1, sticky: a word arrived with FIFO full.
- drop_count_o, out, 8, saturating count of triggers ignored while busy.

Behaviour:
- Reset (async assert, sync release): state IDLE, FIFO emptied.
  - All outputs 0 except s_dat_tready = 1; drop_count_o = 0, overflow_o = 0.
  - Reset asserted mid-operation discards FIFO contents and abandons the request.
- FSM states: IDLE, REQ, RECV, DRAIN.
- IDLE: on trig_i, register base = (trig_addr_i - PRETRIG) mod 2^ADDRLEN, zero-extend it, go to REQ next cycle.
- REQ: m_req_tvalid = 1 and m_req_tdata = base, both held stable until m_req_tvalid && m_req_tready. On that cycle clear in_cnt and go to RECV.
- RECV: each s_dat_tvalid cycle increments in_cnt (RDCNTLEN+1 bits).
  - Word is written to the FIFO if not full.
  - If the FIFO is full, the word is dropped and overflow_o is set (sticky until reset); it is still counted.
  - When in_cnt reaches RDLEN, go to DRAIN.
- s_dat_tvalid outside RECV is ignored (not written, not counted).
- DRAIN: exit to IDLE the cycle after the tlast word transfers.
  - If words were dropped so the FIFO empties with out_cnt < RDLEN, exit to IDLE when the FIFO is empty and in_cnt == RDLEN. No tlast is emitted in that case.
- s_dat_tready is combinational on the registered free count: free > MARGIN. It is independent of state.
- Output path:
  - FIFO is first-word-fall-through; m_axis_tvalid = !empty.
  - Transfer on m_axis_tvalid && m_axis_tready.
  - out_cnt counts transfers per event, cleared on REQ acceptance.
  - m_axis_tlast = m_axis_tvalid && (out_cnt == RDLEN-1).
- Latency: a word accepted at s_dat appears on m_axis_tdata 1 cycle later when the FIFO is empty.
- Sustained throughput: 1 word/cycle.
- Trigger while busy_o = 1 is ignored; drop_count_o increments, saturating at 255.
- Trigger in the same cycle busy_o falls is also ignored, because busy is evaluated registered.
- Address wrap: trig_addr_i < PRETRIG wraps modulo 2^ADDRLEN; upper ADDRBITS-ADDRLEN bits are 0.

Decomposition:
- pueo_readout_pkg: state enum (IDLE, REQ, RECV, DRAIN), MARGIN default, 72-bit word typedef.
- One sub-module: pueo_readout_fifo, a synchronous FWFT FIFO with a registered free-count output and async active-low reset.

Test Plan:
- trig_addr_i = 0x0100 with PRETRIG = 256 -> m_req_tdata = 0x0000. trig_addr_i = 0x0010 -> 0x3F10 (wrap). Request held until m_req_tready.
- Full event: 1024 words streamed, m_axis_tready = 1 -> 1024 outputs in order, tlast only on word 1023, busy_o low after, overflow_o = 0.
- Backpressure: m_axis_tready low 50 cycles, buffer model stops within 4 cycles of s_dat_tready falling -> no overflow, data intact, s_dat_tready low at free <= 4.
- Buffer model ignores s_dat_tready, FIFO_DEPTH = 16 -> overflow_o = 1; FSM still returns to IDLE after 1024 input words, no tlast.
- 3 triggers during busy -> drop_count_o = 3. 300 triggers -> saturates at 255.
- memclk_rstn_i pulsed low mid-RECV -> all outputs at reset values immediately; the next trigger runs a clean full event.

Source files
------------

// File: rtl/pueo_readout_pkg.sv
// Shared types for the URAM readout controller: FSM states and the 72-bit
// sample word (six 12-bit samples).
package pueo_readout_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RECV,
    DRAIN
  } state_t;

  localparam int MARGIN_DEFAULT = 4;
  localparam int WORD_W = 72;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/pueo_readout_fifo.sv
// First-word-fall-through FIFO with a registered free-slot count, so the
// early-warning ready derived from it never sees a combinational path.
module pueo_readout_fifo
  import pueo_readout_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  word_t                  wr_data,
  input  logic                   rd_en,
  output word_t                  rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] free
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  word_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   free_reg;
  logic          do_wr, do_rd;

  assign empty   = (free_reg == DEPTH_C);
  assign full    = (free_reg == '0);
  assign free    = free_reg;
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  // Asynchronous read gives the head word on the cycle after it was written.
  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      free_reg   <= DEPTH_C;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   free_reg <= free_reg - 1'b1;
        2'b01:   free_reg <= free_reg + 1'b1;
        default: free_reg <= free_reg;
      endcase
    end
  end

endmodule

// File: rtl/pueo_uram_readout_ctrl.sv
// Readout requester: on a trigger issues one pretrigger-adjusted read to the
// URAM buffer, absorbs RDLEN words into a FIFO and re-emits them as AXI4-Stream.
module pueo_uram_readout_ctrl
  import pueo_readout_pkg::*;
#(
  parameter int ADDRLEN    = 14,
  parameter int ADDRBITS   = 16,
  parameter int RDLEN      = 1024,
  parameter int PRETRIG    = 256,
  parameter int FIFO_DEPTH = 16,
  parameter int MARGIN     = MARGIN_DEFAULT
) (
  input  logic                memclk,
  input  logic                memclk_rstn_i,
  input  logic                trig_i,
  input  logic [ADDRLEN-1:0]  trig_addr_i,
  output logic                busy_o,
  output logic [ADDRBITS-1:0] m_req_tdata,
  output logic                m_req_tvalid,
  input  logic                m_req_tready,
  input  word_t               s_dat_tdata,
  input  logic                s_dat_tvalid,
  output logic                s_dat_tready,
  output word_t               m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                overflow_o,
  output logic [7:0]          drop_count_o
);

  localparam int RDCNTLEN = $clog2(RDLEN);
  localparam int FW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDRLEN-1:0] PRETRIG_C = ADDRLEN'(PRETRIG);
  localparam logic [RDCNTLEN:0]  RDLEN_C   = (RDCNTLEN + 1)'(RDLEN);
  localparam logic [RDCNTLEN:0]  RDLAST_C  = (RDCNTLEN + 1)'(RDLEN - 1);
  localparam logic [FW-1:0]      MARGIN_C  = FW'(MARGIN);

  state_t               state_reg, state_next;
  logic [ADDRLEN-1:0]   base_reg;
  logic [RDCNTLEN:0]    in_cnt_reg, out_cnt_reg;
  logic                 overflow_reg;
  logic [7:0]           drop_reg;
  logic                 fifo_wr, fifo_empty, fifo_full, xfer;
  logic [FW-1:0]        fifo_free;
  word_t                fifo_data;

  assign busy_o        = (state_reg != IDLE);
  assign m_req_tdata   = ADDRBITS'(base_reg);
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_data;
  assign xfer          = m_axis_tvalid && m_axis_tready;
  assign m_axis_tlast  = m_axis_tvalid && (out_cnt_reg == RDLAST_C);
  assign s_dat_tready  = (fifo_free > MARGIN_C);
  assign overflow_o    = overflow_reg;
  assign drop_count_o  = drop_reg;

  always_comb begin
    state_next   = state_reg;
    m_req_tvalid = 1'b0;
    fifo_wr      = 1'b0;
    case (state_reg)
      IDLE: if (trig_i) state_next = REQ;
      REQ: begin
        m_req_tvalid = 1'b1;
        if (m_req_tready) state_next = RECV;
      end
      RECV: begin
        fifo_wr = s_dat_tvalid && !fifo_full;
        if (s_dat_tvalid && (in_cnt_reg == RDLAST_C)) state_next = DRAIN;
      end
      DRAIN: begin
        // Second term covers events that lost words and so never reach tlast.
        if ((xfer && m_axis_tlast) || (fifo_empty && (in_cnt_reg == RDLEN_C)))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge memclk or negedge memclk_rstn_i) begin
    if (!memclk_rstn_i) begin
      state_reg    <= IDLE;
      base_reg     <= '0;
      in_cnt_reg   <= '0;
      out_cnt_reg  <= '0;
      overflow_reg <= 1'b0;
      drop_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && trig_i) base_reg <= trig_addr_i - PRETRIG_C;
      if (busy_o && trig_i && (drop_reg != 8'hFF)) drop_reg <= drop_reg + 8'd1;
      if ((state_reg == REQ) && m_req_tready) begin
        in_cnt_reg  <= '0;
        out_cnt_reg <= '0;
      end else begin
        if ((state_reg == RECV) && s_dat_tvalid) in_cnt_reg <= in_cnt_reg + 1'b1;
        if (xfer) out_cnt_reg <= out_cnt_reg + 1'b1;
      end
      if ((state_reg == RECV) && s_dat_tvalid && fifo_full) overflow_reg <= 1'b1;
    end
  end

  pueo_readout_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (memclk),
    .rst_n  (memclk_rstn_i),
    .wr_en  (fifo_wr),
    .wr_data(s_dat_tdata),
    .rd_en  (xfer),
    .rd_data(fifo_data),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .free   (fifo_free)
  );

endmodule

// File: tb/tb_pueo_uram_readout_ctrl.sv
// Bench for pueo_uram_readout_ctrl: table of readout events driven through a
// buffer model, with a scoreboard queue on the output stream.
module tb_pueo_uram_readout_ctrl;

  localparam int RDLEN      = 1024;
  localparam int FIFO_DEPTH = 16;
  localparam int MARGIN     = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig_i = 1'b0;
  logic [13:0] trig_addr_i = '0;
  logic        busy_o;
  logic [15:0] m_req_tdata;
  logic        m_req_tvalid;
  logic        m_req_tready = 1'b0;
  logic [71:0] s_dat_tdata = '0;
  logic        s_dat_tvalid = 1'b0;
  logic        s_dat_tready;
  logic [71:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        overflow_o;
  logic [7:0]  drop_count_o;

  pueo_uram_readout_ctrl #(
    .ADDRLEN(14), .ADDRBITS(16), .RDLEN(RDLEN), .PRETRIG(256),
    .FIFO_DEPTH(FIFO_DEPTH), .MARGIN(MARGIN)
  ) dut (
    .memclk       (clk),
    .memclk_rstn_i(rst_n),
    .trig_i       (trig_i),
    .trig_addr_i  (trig_addr_i),
    .busy_o       (busy_o),
    .m_req_tdata  (m_req_tdata),
    .m_req_tvalid (m_req_tvalid),
    .m_req_tready (m_req_tready),
    .s_dat_tdata  (s_dat_tdata),
    .s_dat_tvalid (s_dat_tvalid),
    .s_dat_tready (s_dat_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .overflow_o   (overflow_o),
    .drop_count_o (drop_count_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // mode 0: full rate; 1: downstream stall honoured via ready; 2: buffer ignores ready
  typedef struct {
    logic [13:0] addr;
    logic [15:0] exp_req;
    int          req_wait;
    int          mode;
    bit          trig_end;
    int          exp_words;
    int          exp_tlast;
    bit          exp_ovf;
  } vec_t;

  typedef struct packed {
    logic [71:0] data;
    logic        last;
  } exp_t;

  vec_t vecs [4];
  exp_t sb [$];
  vec_t cur;
  int   cur_id, sent, rcvd, tlast_seen, recv_start;
  int   first_in_cyc, first_out_cyc, last_out_cyc;
  bit   drv_done, ev_done;
  int   checks = 0, errors = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    check(name, 72'(act), 72'(exp));
  endtask

  function automatic logic [71:0] mk_word(input int id, input int i);
    logic [31:0] h;
    h = 32'(i) * 32'h9E3779B1 + 32'(id);
    return {8'(id), 16'hC0DE, 16'(i), h};
  endfunction

  task automatic check_reset_vals(input string tag);
    checki({tag, "_busy"}, busy_o, 0);
    checki({tag, "_req_valid"}, m_req_tvalid, 0);
    checki({tag, "_req_data"}, m_req_tdata, 0);
    checki({tag, "_sdat_ready"}, s_dat_tready, 1);
    checki({tag, "_axis_valid"}, m_axis_tvalid, 0);
    check({tag, "_axis_data"}, m_axis_tdata, 72'(0));
    checki({tag, "_axis_last"}, m_axis_tlast, 0);
    checki({tag, "_overflow"}, overflow_o, 0);
    checki({tag, "_drop"}, drop_count_o, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic pulse_trig(input logic [13:0] a);
    @(posedge clk); #1; trig_i = 1'b1; trig_addr_i = a;
    @(posedge clk); #1; trig_i = 1'b0;
  endtask

  task automatic run_event(input vec_t v, input int id);
    cur = v; cur_id = id;
    sent = 0; rcvd = 0; tlast_seen = 0; drv_done = 0; ev_done = 0;
    first_in_cyc = 0; first_out_cyc = 0; last_out_cyc = 0;
    sb.delete();
    pulse_trig(v.addr);
    // junk words while the request is outstanding must be ignored
    s_dat_tvalid = (v.req_wait > 0);
    s_dat_tdata  = '1;
    @(negedge clk);
    checki("req_valid", m_req_tvalid, 1);
    check("req_addr", 72'(m_req_tdata), 72'(v.exp_req));
    for (int w = 0; w < v.req_wait; w++) begin
      @(negedge clk);
      check("req_hold", {55'(0), m_req_tvalid, m_req_tdata}, {55'(0), 1'b1, v.exp_req});
    end
    @(posedge clk); #1; m_req_tready = 1'b1;
    @(posedge clk); #1; m_req_tready = 1'b0;
    recv_start = cyc;
    fork
      begin : drv
        logic [4:0]  rh;
        logic [71:0] w;
        exp_t        e;
        int          i, guard;
        rh = '1; i = 0; guard = 0;
        while (i < RDLEN && guard < 6000) begin
          rh = {rh[3:0], s_dat_tready};
          // honouring buffer reacts to ready seen 4 cycles earlier
          if (cur.mode == 2 || rh[4]) begin
            w = mk_word(cur_id, i);
            s_dat_tvalid = 1'b1;
            s_dat_tdata  = w;
            if (cur.mode != 2 || i < FIFO_DEPTH) begin
              e.data = w;
              e.last = (cur.mode != 2) && (i == RDLEN - 1);
              sb.push_back(e);
            end
            if (i == 0) first_in_cyc = cyc;
            i++; sent++;
          end else begin
            s_dat_tvalid = 1'b0;
          end
          guard++;
          @(posedge clk); #1;
        end
        s_dat_tvalid = 1'b0;
        drv_done = 1'b1;
      end
      begin : snk
        exp_t e;
        int   to;
        bit   idle_pending;
        to = 0; idle_pending = 0;
        while (!ev_done && to < 6000) begin
          trig_i = 1'b0;
          if (cur.mode == 2) m_axis_tready = drv_done;
          else m_axis_tready = !(cur.mode == 1 && cyc >= recv_start + 100 && cyc < recv_start + 150);
          @(negedge clk);
          if (idle_pending) begin
            checki("idle_after_tlast", busy_o, 0);
            idle_pending = 0;
          end
          if (cur.mode == 1 && cyc == recv_start + 149) begin
            checki("bp_ready_low", s_dat_tready, 0);
            checki("bp_occupancy", sent - rcvd, FIFO_DEPTH);
          end
          if (m_axis_tvalid && m_axis_tready) begin
            checki("sb_has_entry", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
              e = sb.pop_front();
              check("axis_data", m_axis_tdata, e.data);
              checki("axis_tlast", m_axis_tlast, e.last);
            end
            if (rcvd == 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
            rcvd++;
            if (m_axis_tlast) begin
              tlast_seen++;
              idle_pending = 1;
              if (cur.trig_end) trig_i = 1'b1;
            end
          end
          ev_done = drv_done && (sb.size() == 0) && !busy_o && !idle_pending;
          if (!ev_done) begin
            @(posedge clk); #1;
            to++;
          end
        end
        trig_i = 1'b0;
        m_axis_tready = 1'b0;
      end
    join
    checki("ev_done", ev_done, 1);
    checki("ev_words", rcvd, v.exp_words);
    checki("ev_tlast", tlast_seen, v.exp_tlast);
    checki("ev_overflow", overflow_o, v.exp_ovf);
    checki("ev_drop", drop_count_o, v.trig_end ? 1 : 0);
    checki("ev_sdat_ready", s_dat_tready, 1);
    if (v.mode == 0) begin
      checki("latency", first_out_cyc - first_in_cyc, 1);
      checki("throughput", last_out_cyc - first_out_cyc, RDLEN - 1);
    end
    $display("event %0d: addr=0x%04h req=0x%04h words=%0d tlast=%0d overflow=%0b drop=%0d",
             id, v.addr, v.exp_req, rcvd, tlast_seen, overflow_o, drop_count_o);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{14'h0100, 16'h0000, 0, 0, 1'b0, RDLEN, 1, 1'b0};
    vecs[1] = '{14'h0010, 16'h3F10, 5, 1, 1'b1, RDLEN, 1, 1'b0};
    vecs[2] = '{14'h00FF, 16'h3FFF, 2, 0, 1'b0, RDLEN, 1, 1'b0};
    vecs[3] = '{14'h2345, 16'h2245, 3, 2, 1'b0, FIFO_DEPTH, 0, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1; rst_n = 1'b1;

    for (int k = 0; k < 4; k++) begin
      do_reset();
      run_event(vecs[k], k);
    end

    // triggers while busy, then reset in the middle of RECV
    do_reset();
    pulse_trig(14'h0500);
    repeat (3) pulse_trig(14'h0123);
    @(negedge clk);
    checki("drop_3", drop_count_o, 3);
    check("drop_req_kept", 72'(m_req_tdata), 72'(16'h0400));
    @(posedge clk); #1; m_req_tready = 1'b1;
    @(posedge clk); #1; m_req_tready = 1'b0; m_axis_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_dat_tvalid = 1'b1;
      s_dat_tdata  = mk_word(8, i);
      @(posedge clk); #1;
    end
    s_dat_tvalid = 1'b0;
    repeat (297) pulse_trig(14'h0777);
    @(negedge clk);
    checki("drop_sat", drop_count_o, 255);
    checki("recv_busy", busy_o, 1);
    check("recv_head", m_axis_tdata, mk_word(8, 0));
    $display("drop test: drop_count=%0d after 300 triggers", drop_count_o);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(posedge clk); #1; rst_n = 1'b1;
    run_event(vecs[0], 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
